// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised register file: one write port, two registered read ports, clear engine
//
// Purpose: NUM_REGS x WORD_SIZE register file placed between the control unit
// and the datapath operand buses. Same-cycle write-to-read bypass (write-first).
// A sequential clear engine zeroes one register per cycle while BUSY is high.
//
// Ports:
//   CLK                 rising-edge clock
//   RST_N               asynchronous active-low reset
//   WR_EN/WR_ADDR/WR_DATA              write port
//   RD_EN_A/RD_ADDR_A -> RD_DATA_A/RD_VALID_A  read port A (1-cycle latency)
//   RD_EN_B/RD_ADDR_B -> RD_DATA_B/RD_VALID_B  read port B (1-cycle latency)
//   CLR_REQ             start the clear engine
//   BUSY                clear engine active
module regfile_mp #(
    parameter int WORD_SIZE = 19,
    parameter int NUM_REGS  = 8,
    parameter int ZERO_REG  = 0,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 WR_EN,
    input  logic [AW-1:0]        WR_ADDR,
    input  logic [WORD_SIZE-1:0] WR_DATA,
    input  logic                 RD_EN_A,
    input  logic [AW-1:0]        RD_ADDR_A,
    output logic [WORD_SIZE-1:0] RD_DATA_A,
    output logic                 RD_VALID_A,
    input  logic                 RD_EN_B,
    input  logic [AW-1:0]        RD_ADDR_B,
    output logic [WORD_SIZE-1:0] RD_DATA_B,
    output logic                 RD_VALID_B,
    input  logic                 CLR_REQ,
    output logic                 BUSY
);

    typedef enum logic {
        S_IDLE,
        S_CLEARING
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [AW-1:0]        r_clr_idx;
    logic [WORD_SIZE-1:0] r_regs [NUM_REGS];

    logic [WORD_SIZE-1:0] r_rd_data_a;
    logic [WORD_SIZE-1:0] r_rd_data_b;
    logic                 r_rd_valid_a;
    logic                 r_rd_valid_b;

    logic                 w_idle;
    logic                 w_clr_last;
    logic                 w_wr_ok;
    logic                 w_rd_ok_a;
    logic                 w_rd_ok_b;
    logic [WORD_SIZE-1:0] w_rd_data_a;
    logic [WORD_SIZE-1:0] w_rd_data_b;

    assign w_idle     = (r_state == S_IDLE);
    assign w_clr_last = (r_clr_idx == AW'(NUM_REGS - 1));

    // An access is real only if the index exists and is not the hardwired zero register.
    assign w_wr_ok   = w_idle && WR_EN && (int'(WR_ADDR) < NUM_REGS)
                       && !((ZERO_REG != 0) && (WR_ADDR == '0));
    assign w_rd_ok_a = (int'(RD_ADDR_A) < NUM_REGS) && !((ZERO_REG != 0) && (RD_ADDR_A == '0));
    assign w_rd_ok_b = (int'(RD_ADDR_B) < NUM_REGS) && !((ZERO_REG != 0) && (RD_ADDR_B == '0));

    // Read muxes: bypass only from a write that will actually land.
    always_comb begin
        w_rd_data_a = '0;
        if (w_wr_ok && (WR_ADDR == RD_ADDR_A)) begin
            w_rd_data_a = WR_DATA;
        end else if (w_rd_ok_a) begin
            w_rd_data_a = r_regs[RD_ADDR_A];
        end
    end

    always_comb begin
        w_rd_data_b = '0;
        if (w_wr_ok && (WR_ADDR == RD_ADDR_B)) begin
            w_rd_data_b = WR_DATA;
        end else if (w_rd_ok_b) begin
            w_rd_data_b = r_regs[RD_ADDR_B];
        end
    end

    // Clear FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (CLR_REQ) w_state_next = S_CLEARING;
            S_CLEARING: if (w_clr_last) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_CLEARING) begin
                r_clr_idx <= w_clr_last ? '0 : r_clr_idx + AW'(1);
            end
        end
    end

    // Storage: the clear engine owns the array while CLEARING.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_CLEARING) begin
            r_regs[r_clr_idx] <= '0;
        end else if (w_wr_ok) begin
            r_regs[WR_ADDR] <= WR_DATA;
        end
    end

    // Registered read ports; data holds whenever no read is serviced.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_data_a  <= '0;
            r_rd_data_b  <= '0;
            r_rd_valid_a <= 1'b0;
            r_rd_valid_b <= 1'b0;
        end else begin
            r_rd_valid_a <= w_idle && RD_EN_A;
            r_rd_valid_b <= w_idle && RD_EN_B;
            if (w_idle && RD_EN_A) r_rd_data_a <= w_rd_data_a;
            if (w_idle && RD_EN_B) r_rd_data_b <= w_rd_data_b;
        end
    end

    assign RD_DATA_A  = r_rd_data_a;
    assign RD_DATA_B  = r_rd_data_b;
    assign RD_VALID_A = r_rd_valid_a;
    assign RD_VALID_B = r_rd_valid_b;
    assign BUSY       = (r_state == S_CLEARING);

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (default instance and a 6-reg zero-reg instance)
module tb_regfile_mp;

    logic        CLK;
    logic        RST_N;
    logic        wr_en     [2];
    logic [2:0]  wr_addr   [2];
    logic [18:0] wr_data   [2];
    logic        rd_en_a   [2];
    logic [2:0]  rd_addr_a [2];
    logic [18:0] rd_data_a [2];
    logic        rd_valid_a[2];
    logic        rd_en_b   [2];
    logic [2:0]  rd_addr_b [2];
    logic [18:0] rd_data_b [2];
    logic        rd_valid_b[2];
    logic        clr_req   [2];
    logic        busy      [2];

    logic [18:0] q_a0[$];
    logic [18:0] q_b0[$];
    logic [18:0] q_a1[$];
    logic [18:0] q_b1[$];

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp u_dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .WR_EN(wr_en[0]), .WR_ADDR(wr_addr[0]), .WR_DATA(wr_data[0]),
        .RD_EN_A(rd_en_a[0]), .RD_ADDR_A(rd_addr_a[0]), .RD_DATA_A(rd_data_a[0]), .RD_VALID_A(rd_valid_a[0]),
        .RD_EN_B(rd_en_b[0]), .RD_ADDR_B(rd_addr_b[0]), .RD_DATA_B(rd_data_b[0]), .RD_VALID_B(rd_valid_b[0]),
        .CLR_REQ(clr_req[0]), .BUSY(busy[0])
    );

    regfile_mp #(.WORD_SIZE(19), .NUM_REGS(6), .ZERO_REG(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .WR_EN(wr_en[1]), .WR_ADDR(wr_addr[1]), .WR_DATA(wr_data[1]),
        .RD_EN_A(rd_en_a[1]), .RD_ADDR_A(rd_addr_a[1]), .RD_DATA_A(rd_data_a[1]), .RD_VALID_A(rd_valid_a[1]),
        .RD_EN_B(rd_en_b[1]), .RD_ADDR_B(rd_addr_b[1]), .RD_DATA_B(rd_data_b[1]), .RD_VALID_B(rd_valid_b[1]),
        .CLR_REQ(clr_req[1]), .BUSY(busy[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every presented read result is matched against the oldest expectation.
    always @(negedge CLK) begin
        if (rd_valid_a[0]) begin
            if (q_a0.size() == 0) check("dut0 A unexpected valid", 1, 0);
            else check("dut0 A data", {13'd0, rd_data_a[0]}, {13'd0, q_a0.pop_front()});
        end
        if (rd_valid_b[0]) begin
            if (q_b0.size() == 0) check("dut0 B unexpected valid", 1, 0);
            else check("dut0 B data", {13'd0, rd_data_b[0]}, {13'd0, q_b0.pop_front()});
        end
        if (rd_valid_a[1]) begin
            if (q_a1.size() == 0) check("dut1 A unexpected valid", 1, 0);
            else check("dut1 A data", {13'd0, rd_data_a[1]}, {13'd0, q_a1.pop_front()});
        end
        if (rd_valid_b[1]) begin
            if (q_b1.size() == 0) check("dut1 B unexpected valid", 1, 0);
            else check("dut1 B data", {13'd0, rd_data_b[1]}, {13'd0, q_b1.pop_front()});
        end
    end

    // Advance one edge, then release all strobes.
    task automatic tick();
        @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            wr_en[d]   = 1'b0;
            rd_en_a[d] = 1'b0;
            rd_en_b[d] = 1'b0;
            clr_req[d] = 1'b0;
        end
    endtask

    task automatic wr(input int d, input logic [2:0] addr, input logic [18:0] data);
        wr_en[d]   = 1'b1;
        wr_addr[d] = addr;
        wr_data[d] = data;
    endtask

    task automatic rd_a(input int d, input logic [2:0] addr, input logic [18:0] exp);
        rd_en_a[d]   = 1'b1;
        rd_addr_a[d] = addr;
        if (d == 0) q_a0.push_back(exp); else q_a1.push_back(exp);
    endtask

    task automatic rd_b(input int d, input logic [2:0] addr, input logic [18:0] exp);
        rd_en_b[d]   = 1'b1;
        rd_addr_b[d] = addr;
        if (d == 0) q_b0.push_back(exp); else q_b1.push_back(exp);
    endtask

    task automatic check_reset_outputs(input int d);
        check("reset RD_DATA_A", {13'd0, rd_data_a[d]}, 0);
        check("reset RD_DATA_B", {13'd0, rd_data_b[d]}, 0);
        check("reset RD_VALID_A", {31'd0, rd_valid_a[d]}, 0);
        check("reset RD_VALID_B", {31'd0, rd_valid_b[d]}, 0);
        check("reset BUSY", {31'd0, busy[d]}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with non-zero buses present
        RST_N = 1'b0;
        for (int d = 0; d < 2; d++) begin
            wr_en[d] = 1'b1; wr_addr[d] = 3'd3; wr_data[d] = 19'h7FFFF;
            rd_en_a[d] = 1'b1; rd_addr_a[d] = 3'd1;
            rd_en_b[d] = 1'b1; rd_addr_b[d] = 3'd2;
            clr_req[d] = 1'b1;
        end
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        for (int d = 0; d < 2; d++) begin
            wr_en[d] = 1'b0; rd_en_a[d] = 1'b0; rd_en_b[d] = 1'b0; clr_req[d] = 1'b0;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // All registers read zero after reset
        for (int i = 0; i < 8; i++) begin
            rd_a(0, 3'(i), 19'h00000);
            rd_b(0, 3'(7 - i), 19'h00000);
            tick();
        end

        // Write then read on both ports
        wr(0, 3'd5, 19'h7FFFF); tick();
        rd_a(0, 3'd5, 19'h7FFFF); rd_b(0, 3'd5, 19'h7FFFF); tick();
        tick();
        check("hold RD_DATA_A", {13'd0, rd_data_a[0]}, 32'h7FFFF);
        check("idle RD_VALID_A", {31'd0, rd_valid_a[0]}, 0);

        // Bypass on A while B reads an untouched register
        wr(0, 3'd2, 19'h0ABCD); tick();
        wr(0, 3'd3, 19'h12345); rd_a(0, 3'd3, 19'h12345); rd_b(0, 3'd2, 19'h0ABCD); tick();
        rd_a(0, 3'd3, 19'h12345); tick();

        // Fill, then clear; a read coincident with CLR_REQ is still serviced
        for (int i = 0; i < 8; i++) begin
            wr(0, 3'(i), 19'h100 + 19'(i)); tick();
        end
        clr_req[0] = 1'b1; rd_a(0, 3'd1, 19'h00101); tick();
        check("clear BUSY c1", {31'd0, busy[0]}, 1);
        for (int c = 2; c <= 8; c++) begin
            wr(0, 3'd4, 19'h00007);
            rd_en_a[0] = 1'b1; rd_addr_a[0] = 3'd4;
            rd_en_b[0] = 1'b1; rd_addr_b[0] = 3'd6;
            clr_req[0] = 1'b1;
            tick();
            check("clear BUSY high", {31'd0, busy[0]}, 1);
        end
        wr(0, 3'd4, 19'h00007); clr_req[0] = 1'b1; tick();
        check("clear BUSY done", {31'd0, busy[0]}, 0);
        for (int i = 0; i < 8; i++) begin
            rd_a(0, 3'(i), 19'h00000); tick();
        end

        // Reset in the middle of a clear
        for (int i = 0; i < 8; i++) begin
            wr(0, 3'(i), 19'h40000 | 19'(i)); tick();
        end
        clr_req[0] = 1'b1; tick();
        tick(); tick();
        check("midclear BUSY before reset", {31'd0, busy[0]}, 1);
        RST_N = 1'b0;
        #1;
        check("midclear BUSY in reset", {31'd0, busy[0]}, 0);
        check("midclear RD_DATA_A", {13'd0, rd_data_a[0]}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check("after reset BUSY", {31'd0, busy[0]}, 0);
        for (int i = 0; i < 8; i++) begin
            rd_b(0, 3'(i), 19'h00000); tick();
        end

        // Six-register, zero-register instance: out-of-range and reg 0 are dropped
        wr(1, 3'd5, 19'h2AAAA); tick();
        wr(1, 3'd7, 19'h00001); rd_a(1, 3'd7, 19'h00000); tick();
        wr(1, 3'd6, 19'h00001); tick();
        rd_a(1, 3'd7, 19'h00000); rd_b(1, 3'd5, 19'h2AAAA); tick();
        for (int i = 0; i < 5; i++) begin
            rd_a(1, 3'(i), 19'h00000); tick();
        end
        wr(1, 3'd0, 19'h55555); rd_a(1, 3'd0, 19'h00000); tick();
        rd_b(1, 3'd0, 19'h00000); tick();
        wr(1, 3'd4, 19'h00003); rd_a(1, 3'd4, 19'h00003); rd_b(1, 3'd5, 19'h2AAAA); tick();

        // Every issued read must have been presented
        tick(); tick();
        check("dut0 A pending", q_a0.size(), 0);
        check("dut0 B pending", q_b0.size(), 0);
        check("dut1 A pending", q_a1.size(), 0);
        check("dut1 B pending", q_b1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
